// File: rtl/status_spi_out_pkg.sv
// Shared definitions for the status SPI link: FSM state encoding, SPI mode
// constants and default frame geometry. The receive side imports the same set.
package status_spi_out_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_HOLD
    } spi_state_t;

    // SPI mode 0: clock idles low, data sampled on the rising edge, MSB first.
    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;

    localparam int DEFAULT_WORD_BITS = 16;
    localparam int DEFAULT_WORDS     = 5;

    // Width of the shared duration timer; covers CLK_DIV, CS_SETUP and CS_HOLD.
    localparam int TIMER_W = 16;

endpackage

// File: rtl/status_spi_out_half_period_timer.sv
// Loadable down-counter. tick is high while the count sits at zero, so loading
// D-1 yields a tick on the D-th cycle after the load.
module spi_half_period_timer #(
    parameter int W = 16
) (
    input  logic         Main_Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         tick
);

    logic [W-1:0] count_reg;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign tick = (count_reg == '0);

endmodule

// File: rtl/status_spi_out.sv
// Status SPI transmitter: sends WORDS x WORD_BITS frame, mode 0, MSB first,
// with CS held low across the whole frame and no gaps between words.
module status_spi_out
    import status_spi_out_pkg::*;
#(
    parameter int WORDS     = DEFAULT_WORDS,
    parameter int WORD_BITS = DEFAULT_WORD_BITS,
    parameter int CLK_DIV   = 4,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4
) (
    input  logic                 Main_Clock,
    input  logic                 Reset,
    input  logic                 i_Start,
    input  logic [WORD_BITS-1:0] i_Data0,
    input  logic [WORD_BITS-1:0] i_Data1,
    input  logic [WORD_BITS-1:0] i_Data2,
    input  logic [WORD_BITS-1:0] i_Data3,
    input  logic [WORD_BITS-1:0] i_Data4,
    input  logic [WORD_BITS-1:0] i_Data5,
    input  logic [WORD_BITS-1:0] i_Data6,
    input  logic [WORD_BITS-1:0] i_Data7,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_SPI_CS,
    output logic                 o_SPI_Clock,
    output logic                 o_SPI_Data
);

    localparam int TOTAL = WORDS * WORD_BITS;
    localparam int BIT_W = $clog2(TOTAL);
    localparam int PAD   = (8 - WORDS) * WORD_BITS;

    localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(CS_SETUP - 1);
    localparam logic [TIMER_W-1:0] DIV_LOAD   = TIMER_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(CS_HOLD - 1);

    spi_state_t         state_reg;
    logic [TOTAL-1:0]   shift_reg;
    logic [BIT_W-1:0]   bit_cnt_reg;
    logic               cs_reg;
    logic               sclk_reg;
    logic               mosi_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [8*WORD_BITS-1:0] all_words;
    logic [TOTAL-1:0]       frame_load;
    logic                   last_bit;
    logic                   timer_load;
    logic [TIMER_W-1:0]     timer_value;
    logic                   timer_tick;

    // Word 0 lands in the top bits so shifting left emits words 0..WORDS-1 in order.
    assign all_words  = {i_Data0, i_Data1, i_Data2, i_Data3,
                         i_Data4, i_Data5, i_Data6, i_Data7};
    assign frame_load = TOTAL'(all_words >> PAD);
    assign last_bit   = (bit_cnt_reg == BIT_W'(TOTAL - 1));

    spi_half_period_timer #(
        .W (TIMER_W)
    ) u_timer (
        .Main_Clock (Main_Clock),
        .Reset      (Reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tick       (timer_tick)
    );

    // Reload the timer with the duration of whichever phase is being entered.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_reg)
            ST_IDLE: begin
                if (i_Start) begin
                    timer_load  = 1'b1;
                    timer_value = SETUP_LOAD;
                end
            end
            ST_SETUP, ST_BIT_LOW: begin
                if (timer_tick) begin
                    timer_load  = 1'b1;
                    timer_value = DIV_LOAD;
                end
            end
            ST_BIT_HIGH: begin
                if (timer_tick) begin
                    timer_load  = 1'b1;
                    timer_value = last_bit ? HOLD_LOAD : DIV_LOAD;
                end
            end
            default: begin
            end
        endcase
    end

    // Frame sequencer: owns the shift register, bit counter and all registered outputs.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            cs_reg      <= 1'b1;
            sclk_reg    <= SPI_CPOL;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_Start) begin
                        shift_reg   <= frame_load;
                        mosi_reg    <= frame_load[TOTAL-1];
                        bit_cnt_reg <= '0;
                        cs_reg      <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer_tick) begin
                        state_reg <= ST_BIT_LOW;
                    end
                end
                ST_BIT_LOW: begin
                    if (timer_tick) begin
                        sclk_reg  <= ~SPI_CPOL;
                        state_reg <= ST_BIT_HIGH;
                    end
                end
                ST_BIT_HIGH: begin
                    if (timer_tick) begin
                        sclk_reg <= SPI_CPOL;
                        if (last_bit) begin
                            state_reg <= ST_HOLD;
                        end else begin
                            // Next bit goes out as the clock falls, a full half-period before it is sampled.
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                            shift_reg   <= shift_reg << 1;
                            mosi_reg    <= shift_reg[TOTAL-2];
                            state_reg   <= ST_BIT_LOW;
                        end
                    end
                end
                ST_HOLD: begin
                    if (timer_tick) begin
                        cs_reg    <= 1'b1;
                        mosi_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Busy      = busy_reg;
    assign o_Done      = done_reg;
    assign o_SPI_CS    = cs_reg;
    assign o_SPI_Clock = sclk_reg;
    assign o_SPI_Data  = mosi_reg;

endmodule

// File: tb/tb_status_spi_out.sv
// Directed bench for status_spi_out with an SPI receive model and a word scoreboard.
module tb_status_spi_out;

    localparam int TB_WORDS     = 5;
    localparam int TB_WORD_BITS = 16;
    localparam int TB_CLK_DIV   = 2;
    localparam int TB_CS_SETUP  = 2;
    localparam int TB_CS_HOLD   = 2;
    localparam int FRAME_BITS   = TB_WORDS * TB_WORD_BITS;                              // 80
    localparam int CS_LOW_LEN   = TB_CS_SETUP + FRAME_BITS * 2 * TB_CLK_DIV + TB_CS_HOLD; // 324

    logic        Main_Clock;
    logic        Reset;
    logic        i_Start;
    logic [15:0] i_Data0, i_Data1, i_Data2, i_Data3, i_Data4, i_Data5, i_Data6, i_Data7;
    logic        o_Busy, o_Done, o_SPI_CS, o_SPI_Clock, o_SPI_Data;

    status_spi_out #(
        .WORDS     (TB_WORDS),
        .WORD_BITS (TB_WORD_BITS),
        .CLK_DIV   (TB_CLK_DIV),
        .CS_SETUP  (TB_CS_SETUP),
        .CS_HOLD   (TB_CS_HOLD)
    ) dut (
        .Main_Clock  (Main_Clock),
        .Reset       (Reset),
        .i_Start     (i_Start),
        .i_Data0     (i_Data0),
        .i_Data1     (i_Data1),
        .i_Data2     (i_Data2),
        .i_Data3     (i_Data3),
        .i_Data4     (i_Data4),
        .i_Data5     (i_Data5),
        .i_Data6     (i_Data6),
        .i_Data7     (i_Data7),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_SPI_CS    (o_SPI_CS),
        .o_SPI_Clock (o_SPI_Clock),
        .o_SPI_Data  (o_SPI_Data)
    );

    initial Main_Clock = 1'b0;
    always #5 Main_Clock = ~Main_Clock;

    int checks   = 0;
    int failures = 0;
    int cycle_cnt = 0;

    // Scoreboard and receive-model state
    logic [15:0] exp_q[$];
    logic [15:0] rx_q[$];
    int          acc_q[$];
    logic [15:0] rx_shift = '0;
    int  rx_bits     = 0;
    int  frame_edges = 0;
    int  cs_low_cnt  = 0;
    int  cs_high_run = 0;
    int  last_gap    = 0;
    int  done_cnt    = 0;
    int  last_cs_low = 0;
    int  last_edges  = 0;
    int  last_len    = 0;
    logic prev_sclk  = 1'b0;

    always @(posedge Main_Clock) cycle_cnt++;

    // Receive model, sampled on the falling edge away from DUT updates.
    always @(negedge Main_Clock) begin
        if (Reset) begin
            rx_bits     = 0;
            frame_edges = 0;
            cs_low_cnt  = 0;
            prev_sclk   = 1'b0;
        end else begin
            if (!o_SPI_CS) begin
                cs_low_cnt++;
                if (cs_high_run > 0) begin
                    last_gap    = cs_high_run;
                    cs_high_run = 0;
                end
                if (o_SPI_Clock && !prev_sclk) begin
                    rx_shift = {rx_shift[14:0], o_SPI_Data};
                    rx_bits++;
                    frame_edges++;
                    if (rx_bits % TB_WORD_BITS == 0) rx_q.push_back(rx_shift);
                end
            end else begin
                cs_high_run++;
            end
            if (o_Done) begin
                done_cnt++;
                last_cs_low = cs_low_cnt;
                last_edges  = frame_edges;
                cs_low_cnt  = 0;
                frame_edges = 0;
                rx_bits     = 0;
                if (acc_q.size() > 0) last_len = cycle_cnt - acc_q.pop_front();
                else                  last_len = -1;
            end
            // A start seen here with Busy low is taken at the coming edge.
            if (i_Start && !o_Busy) begin
                acc_q.push_back(cycle_cnt);
                exp_q.push_back(i_Data0);
                exp_q.push_back(i_Data1);
                exp_q.push_back(i_Data2);
                exp_q.push_back(i_Data3);
                exp_q.push_back(i_Data4);
            end
            prev_sclk = o_SPI_Clock;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Main_Clock);
        #2;
    endtask

    task automatic set_words(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                             input logic [15:0] w3, input logic [15:0] w4);
        i_Data0 = w0; i_Data1 = w1; i_Data2 = w2; i_Data3 = w3; i_Data4 = w4;
        i_Data5 = 16'h5A5A; i_Data6 = 16'hC3C3; i_Data7 = 16'h0F0F;
    endtask

    task automatic pulse_start();
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < 2000) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        logic [15:0] e, r;
        check({tag, "_rx_words"}, 32'(rx_q.size()), 32'(TB_WORDS));
        for (int i = 0; i < TB_WORDS; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            r = (rx_q.size() > 0)  ? rx_q.pop_front()  : 16'hzzzz;
            check($sformatf("%s_word%0d", tag, i), 32'(r), 32'(e));
        end
        check({tag, "_cs_low"}, 32'(last_cs_low), 32'(CS_LOW_LEN));
        check({tag, "_edges"}, 32'(last_edges), 32'(FRAME_BITS));
        check({tag, "_done_at"}, 32'(last_len), 32'(CS_LOW_LEN + 1));
        e = o_Busy;
        check({tag, "_busy_after"}, 32'(o_Busy), 32'(i_Start ? 1'b1 : 1'b0));
    endtask

    initial begin
        int bad = 0;
        int d0;
        int n;
        Reset = 1'b1;
        i_Start = 1'b0;
        set_words(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) step();
        check("rst_cs", 32'(o_SPI_CS), 32'd1);
        check("rst_sclk", 32'(o_SPI_Clock), 32'd0);
        check("rst_mosi", 32'(o_SPI_Data), 32'd0);
        check("rst_busy", 32'(o_Busy), 32'd0);
        check("rst_done", 32'(o_Done), 32'd0);

        // Idle for 100 cycles after reset release
        Reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (o_SPI_CS !== 1'b1 || o_SPI_Clock !== 1'b0 || o_SPI_Data !== 1'b0 ||
                o_Busy !== 1'b0 || o_Done !== 1'b0) bad++;
        end
        check("idle_bad_cycles", 32'(bad), 32'd0);

        // Single frame
        set_words(16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234);
        pulse_start();
        check("single_busy", 32'(o_Busy), 32'd1);
        wait_done("single");
        check_frame("single");

        // Back-to-back with Start held
        repeat (5) step();
        set_words(16'h1357, 16'h2468, 16'hFEDC, 16'h0F0F, 16'h7001);
        i_Start = 1'b1;
        wait_done("b2b1");
        check_frame("b2b1");
        set_words(16'h9ABC, 16'h0000, 16'hFFFE, 16'h4321, 16'h8001);
        wait_done("b2b2");
        check_frame("b2b2");
        check("b2b2_gap", 32'(last_gap), 32'd1);
        i_Start = 1'b0;
        wait_done("b2b3");
        check_frame("b2b3");
        check("b2b3_gap", 32'(last_gap), 32'd1);

        // Start while busy is ignored
        repeat (5) step();
        set_words(16'hCAFE, 16'hBEEF, 16'h0102, 16'h7F80, 16'h55AA);
        pulse_start();
        repeat (100) step();
        set_words(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        pulse_start();
        d0 = done_cnt;
        wait_done("busy_start");
        check_frame("busy_start");
        repeat (400) step();
        check("busy_start_done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_start_exp_empty", 32'(exp_q.size()), 32'd0);
        check("busy_start_rx_empty", 32'(rx_q.size()), 32'd0);

        // Data change mid-frame
        set_words(16'h0A0B, 16'h0C0D, 16'h6E6F, 16'h1020, 16'h3040);
        pulse_start();
        repeat (150) step();
        i_Data2 = 16'hDEAD;
        wait_done("data_change");
        check_frame("data_change");

        // Reset at bit 37
        repeat (5) step();
        set_words(16'hF00D, 16'hABCD, 16'h0110, 16'hE001, 16'h2A2A);
        pulse_start();
        n = 0;
        while (rx_bits < 37 && n < 2000) begin
            step();
            n++;
        end
        check("abort_reached_bit37", 32'(rx_bits), 32'd37);
        d0 = done_cnt;
        Reset = 1'b1;
        step();
        check("abort_cs", 32'(o_SPI_CS), 32'd1);
        check("abort_sclk", 32'(o_SPI_Clock), 32'd0);
        check("abort_mosi", 32'(o_SPI_Data), 32'd0);
        check("abort_busy", 32'(o_Busy), 32'd0);
        step();
        exp_q.delete();
        rx_q.delete();
        acc_q.delete();
        Reset = 1'b0;
        repeat (400) step();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_cs_idle", 32'(o_SPI_CS), 32'd1);
        set_words(16'h8421, 16'h1248, 16'hFFFF, 16'h0000, 16'hB00B);
        pulse_start();
        wait_done("after_abort");
        check_frame("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/status_spi_out.md
# status_spi_out

SPI transmitter sending a fixed frame of 16-bit words from the FPGA to the microcontroller. It is the transmit counterpart of the ADC SPI receive path: same framing, bit order and clock polarity, driven in the opposite direction. It runs in the Main_Clock domain and reports synthesis status (current frequency word, harmonic count reached, Freq_Too_High flag, left and right accumulator high words) once per sample period.

## Interface
- WORDS, 5, number of 16-bit words per frame (1..8)
- WORD_BITS, 16, bits per word
- CLK_DIV, 4, Main_Clock cycles per SPI clock half-period (≥1)
- CS_SETUP, 4, cycles from CS falling to the first SPI clock rising edge (≥1)
- CS_HOLD, 4, cycles from the last SPI clock falling edge to CS rising (≥1)

Ports:
- Main_Clock  in  1  system clock, 72 MHz
- Reset  in  1  synchronous, active-high
- i_Start  in  1  request to send a frame; sampled only when o_Busy=0
- i_Data0..i_Data7  in  WORD_BITS each  frame words; only 0..WORDS-1 are used; captured on the accepted start
- o_Busy  out  1  high from the cycle after an accepted start until the o_Done cycle
- o_Done  out  1  one-cycle pulse when the frame completes
- o_SPI_CS  out  1  active-low chip select
- o_SPI_Clock  out  1  SPI clock, idle low
- o_SPI_Data  out  1  MOSI, MSB first

## Operation
- Reset values: o_SPI_CS=1, o_SPI_Clock=0, o_SPI_Data=0, o_Busy=0, o_Done=0, state IDLE.
- SPI mode 0: data changes while the clock is low and is sampled by the receiver on the clock rising edge. Words are sent in order 0..WORDS-1. CS stays low for the whole frame with no gaps between words.
- States: IDLE → SETUP → BIT_LOW → BIT_HIGH → (next bit: BIT_LOW | last bit: HOLD) → IDLE.
- IDLE: on i_Start=1, latch all words into a shift register (WORDS×WORD_BITS), load o_SPI_Data with the MSB of word 0, drive CS low and o_Busy high, then go to SETUP.
- SETUP: count CS_SETUP cycles with the clock low.
- BIT_LOW: clock low for CLK_DIV cycles. On entry (except for the first bit), shift the register left and present the next bit.
- BIT_HIGH: clock high for CLK_DIV cycles. A bit counter of width clog2(WORDS×WORD_BITS) counts the bits.
- HOLD: clock low for CS_HOLD cycles. Then drive CS high and o_Data low, pulse o_Done, drop o_Busy, and return to IDLE.
- i_Start while busy is ignored; it is not queued.
- i_Data changes during a frame have no effect.
- Reset mid-frame aborts the frame: outputs return to their reset values on the next edge and no o_Done is issued.

## Timing
- Accepted start at edge N. CS is low from N+1 for CS_SETUP + WORDS·WORD_BITS·2·CLK_DIV + CS_HOLD cycles.
- o_Done and CS rising occur on the same cycle, and o_Busy=0 on that cycle.
- i_Start=1 on the o_Done cycle is accepted. CS is then high for exactly 1 cycle, which is the minimum inter-frame gap.
- First rising SPI clock edge: CS_SETUP cycles after CS falls.
- Each bit is stable for 2·CLK_DIV cycles: CLK_DIV before the rising edge and CLK_DIV after it.
- With defaults, a frame lasts 4 + 640 + 4 = 648 cycles, which is less than the 1500-cycle sample interval.

## Structure
- Shared package: state encoding, the SPI mode constants (CPOL=0, CPHA=0, MSB_FIRST=1), and the default WORD_BITS and WORDS, shared with the receive side.
- One sub-module, spi_half_period_timer: a loadable down-counter that issues a tick at terminal count. It is reused for the SETUP, BIT_LOW, BIT_HIGH and HOLD durations.
- The shift register and bit counter stay in the top FSM.

## Test plan
- Reset then idle: CS=1, clock=0, data=0, Busy=0 held for 100 cycles with i_Start=0.
- Single frame with WORDS=5, CLK_DIV=2, CS_SETUP=2, CS_HOLD=2 and words 0xA5A5, 0x0001, 0x8000, 0xFFFF, 0x1234. The bench SPI receive model must capture exactly those words. CS must be low for 324 cycles, with o_Done at N+325.
- Back-to-back: i_Start held high continuously. Frames must repeat with exactly one CS-high cycle between them and no dropped or extra clocks (80 rising edges per frame).
- Start while busy: pulse i_Start with different data mid-frame. That pulse is ignored, the frame content is unchanged, and only one o_Done is issued.
- Data change mid-frame: alter i_Data2 after the start. The transmitted word 2 must equal the value latched at the start.
- Reset at bit 37: CS high and clock low on the next edge, no o_Done. A subsequent start sends a complete, correct frame.
